// File: rtl/bp_be_fe_queue_rollback.sv
// FE-to-BE instruction queue with speculative issue, in-order commit and rollback.
// Three pointers: write (wptr), speculative issue (rptr), commit (cptr).
module bp_be_fe_queue_rollback #(
    parameter int els_p   = 8,
    parameter int width_p = 128
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [width_p-1:0]         data_i,
    input  logic                       v_i,
    output logic                       ready_o,
    output logic [width_p-1:0]         data_o,
    output logic                       v_o,
    input  logic                       yumi_i,
    input  logic                       deq_i,
    input  logic                       roll_i,
    input  logic                       clr_i,
    output logic [$clog2(els_p+1)-1:0] count_o,
    output logic [$clog2(els_p+1)-1:0] spec_count_o
);

    localparam int idx_w = $clog2(els_p);
    localparam int ptr_w = idx_w + 1;
    localparam int cnt_w = $clog2(els_p + 1);

    logic [width_p-1:0] r_mem [els_p];
    logic [ptr_w-1:0]   r_wptr;
    logic [ptr_w-1:0]   r_rptr;
    logic [ptr_w-1:0]   r_cptr;

    logic [ptr_w-1:0]   w_count;
    logic [ptr_w-1:0]   w_spec;
    logic               w_full;
    logic               w_enq;

    // The wrap bit makes wptr-cptr reach els_p when full instead of aliasing to 0.
    assign w_count      = r_wptr - r_cptr;
    assign w_spec       = r_rptr - r_cptr;
    assign w_full       = (w_count == ptr_w'(els_p));
    assign w_enq        = v_i & ~w_full & ~clr_i;

    assign ready_o      = ~w_full;
    assign v_o          = (r_rptr != r_wptr);
    assign data_o       = r_mem[r_rptr[idx_w-1:0]];
    assign count_o      = cnt_w'(w_count);
    assign spec_count_o = cnt_w'(w_spec);

    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_mem[r_wptr[idx_w-1:0]] <= data_i;
        end
    end

    // Priority is clr over roll over issue; a roll with deq rewinds past the retired entry.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cptr <= '0;
        end else if (clr_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cptr <= '0;
        end else begin
            if (w_enq) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (roll_i) begin
                if (deq_i) begin
                    r_cptr <= r_cptr + 1'b1;
                    r_rptr <= r_cptr + 1'b1;
                end else begin
                    r_rptr <= r_cptr;
                end
            end else begin
                if (yumi_i) begin
                    r_rptr <= r_rptr + 1'b1;
                end
                if (deq_i) begin
                    r_cptr <= r_cptr + 1'b1;
                end
            end
        end
    end

    a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i)
        !(yumi_i && !v_o));
    a_deq_needs_issued: assert property (@(posedge clk_i) disable iff (reset_i)
        !(deq_i && (w_spec == '0)));

endmodule

// File: tb/tb_bp_be_fe_queue_rollback.sv
// Scoreboard bench: the model keeps uncommitted entries in a queue plus an issue offset,
// and every issue/state observation is compared against it.
module tb_bp_be_fe_queue_rollback;

    localparam int ELS = 8;
    localparam int W   = 128;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic [W-1:0]  data_i;
    logic          v_i;
    logic          ready_o;
    logic [W-1:0]  data_o;
    logic          v_o;
    logic          yumi_i;
    logic          deq_i;
    logic          roll_i;
    logic          clr_i;
    logic [3:0]    count_o;
    logic [3:0]    spec_count_o;

    int vecCount = 0;
    int errCount = 0;

    // Expected entries from the commit point onward; specIdx is how many are issued.
    logic [W-1:0] expQ [$];
    int           specIdx = 0;

    bp_be_fe_queue_rollback #(.els_p(ELS), .width_p(W)) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .data_i       (data_i),
        .v_i          (v_i),
        .ready_o      (ready_o),
        .data_o       (data_o),
        .v_o          (v_o),
        .yumi_i       (yumi_i),
        .deq_i        (deq_i),
        .roll_i       (roll_i),
        .clr_i        (clr_i),
        .count_o      (count_o),
        .spec_count_o (spec_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vecCount++;
        if (obs !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] randData();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic checkState(input string tag);
        checkOutput({tag, ":v_o"}, W'(v_o), W'(specIdx < expQ.size()));
        checkOutput({tag, ":ready_o"}, W'(ready_o), W'(expQ.size() < ELS));
        checkOutput({tag, ":count_o"}, W'(count_o), W'(expQ.size()));
        checkOutput({tag, ":spec_count_o"}, W'(spec_count_o), W'(specIdx));
        if (specIdx < expQ.size()) begin
            checkOutput({tag, ":data_o"}, data_o, expQ[specIdx]);
        end
    endtask

    // Drives one cycle from just after a negedge, updates the model at the posedge,
    // and returns just after the next negedge with the state checked.
    task automatic applyStimulus(input string tag, input logic v, input logic [W-1:0] d,
                                 input logic y, input logic dq, input logic rl, input logic cl);
        logic         accept;
        logic [W-1:0] popped;
        v_i = v; data_i = d; yumi_i = y; deq_i = dq; roll_i = rl; clr_i = cl;
        if (y && !rl && !cl && (specIdx < expQ.size())) begin
            checkOutput({tag, ":issue"}, data_o, expQ[specIdx]);
        end
        accept = v && (expQ.size() < ELS);
        @(posedge clk_i);
        #1;
        if (cl) begin
            expQ.delete();
            specIdx = 0;
        end else begin
            if (accept) expQ.push_back(d);
            if (rl) begin
                if (dq) popped = expQ.pop_front();
                specIdx = 0;
            end else begin
                if (y) specIdx++;
                if (dq) begin
                    popped = expQ.pop_front();
                    specIdx--;
                end
            end
        end
        v_i = 0; yumi_i = 0; deq_i = 0; roll_i = 0; clr_i = 0;
        @(negedge clk_i);
        checkState(tag);
    endtask

    task automatic enq(input string tag, input logic [W-1:0] d);
        applyStimulus(tag, 1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic issue(input string tag);
        applyStimulus(tag, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic flush(input string tag);
        applyStimulus(tag, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        logic [W-1:0] a, b, c;
        logic         rv, ry, rd, rr;
        reset_i = 1'b1;
        v_i = 0; data_i = '0; yumi_i = 0; deq_i = 0; roll_i = 0; clr_i = 0;
        @(negedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
        checkState("reset");

        // Asynchronous reset in the middle of a cycle with live entries.
        for (int i = 0; i < 3; i++) enq("rst_enq", randData());
        issue("rst_iss");
        issue("rst_iss");
        #2 reset_i = 1'b1;
        #1;
        checkOutput("rst_async:v_o", W'(v_o), W'(0));
        checkOutput("rst_async:ready_o", W'(ready_o), W'(1));
        checkOutput("rst_async:count_o", W'(count_o), W'(0));
        checkOutput("rst_async:spec_count_o", W'(spec_count_o), W'(0));
        expQ.delete();
        specIdx = 0;
        @(negedge clk_i);
        reset_i = 1'b0;
        checkState("rst_after");

        // Fill to capacity; the ninth entry must be dropped.
        for (int i = 0; i < 9; i++) enq("full_enq", randData());
        checkOutput("full:ready_o", W'(ready_o), W'(0));
        checkOutput("full:count_o", W'(count_o), W'(ELS));
        issue("full_iss");
        applyStimulus("full_deq", 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("full_freed:ready_o", W'(ready_o), W'(1));
        flush("full_clr");

        // Roll back two speculatively issued entries.
        a = randData(); b = randData(); c = randData();
        enq("roll_enq", a); enq("roll_enq", b); enq("roll_enq", c);
        issue("roll_iss"); issue("roll_iss");
        checkOutput("roll:spec2", W'(spec_count_o), W'(2));
        applyStimulus("roll", 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("roll:data_is_A", data_o, a);
        checkOutput("roll:count3", W'(count_o), W'(3));
        flush("roll_clr");

        // Roll together with commit lands on the entry after the retired one.
        a = randData(); b = randData();
        enq("rdq_enq", a); enq("rdq_enq", b);
        issue("rdq_iss");
        applyStimulus("rdq", 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("rdq:data_is_B", data_o, b);
        checkOutput("rdq:count1", W'(count_o), W'(1));
        flush("rdq_clr");

        // Clear wins over a same-cycle enqueue; C must never surface.
        a = randData(); b = randData(); c = randData();
        enq("clr_enq", a); enq("clr_enq", b);
        applyStimulus("clr_v", 1'b1, c, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("clr:v_o", W'(v_o), W'(0));
        checkOutput("clr:count0", W'(count_o), W'(0));
        a = randData();
        enq("clr_post", a);
        checkOutput("clr:next_is_new", data_o, a);
        issue("clr_post_iss");
        flush("clr_done");

        // Random legal traffic across pointer wrap.
        for (int i = 0; i < 40; i++) begin
            rv = ($urandom_range(0, 9) < 7);
            ry = ($urandom_range(0, 9) < 6) && (specIdx < expQ.size());
            rd = ($urandom_range(0, 9) < 5) && (specIdx > 0);
            rr = ($urandom_range(0, 99) < 8);
            applyStimulus("wrap", rv, randData(), ry, rd, rr, 1'b0);
            checkOutput("wrap:count_le8", W'(count_o <= 4'(ELS)), W'(1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
